// File: rtl/arbitro_sumador_restador.sv
// Arbiter that sequences increment/decrement requests onto an external
// up/down counter. It grants at most one update every two cycles, alternates
// priority on conflict and never steps the counter past its bounds.
module arbitro_sumador_restador #(
  parameter int BITS_VALOR = 4,
  parameter int VALOR_MAX  = 15,
  parameter int VALOR_MIN  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sol_suma,
  input  logic                  sol_resta,
  input  logic [BITS_VALOR-1:0] valor_actual,
  output logic                  actualizar,
  output logic                  operacion,
  output logic                  ack_suma,
  output logic                  ack_resta,
  output logic                  lleno,
  output logic                  vacio,
  output logic                  ocupado
);

  localparam logic [BITS_VALOR-1:0] LP_MAX = BITS_VALOR'(VALOR_MAX);
  localparam logic [BITS_VALOR-1:0] LP_MIN = BITS_VALOR'(VALOR_MIN);

  typedef enum logic {
    REPOSO     = 1'b0,
    ACTUALIZAR = 1'b1
  } estado_t;

  estado_t r_state, w_next_state;

  // r_prio_suma = 1 means suma wins the next conflict
  logic r_prio_suma, w_nxt_prio_suma;
  logic r_actualizar, r_operacion, r_ack_suma, r_ack_resta, r_ocupado;
  logic w_nxt_actualizar, w_nxt_operacion, w_nxt_ack_suma, w_nxt_ack_resta, w_nxt_ocupado;

  logic w_lleno, w_vacio;
  logic w_eleg_suma, w_eleg_resta;
  logic w_grant_suma, w_grant_resta;

  // Bound flags are plain unsigned compares on the live counter value
  assign w_lleno = (valor_actual >= LP_MAX);
  assign w_vacio = (valor_actual <= LP_MIN);

  // A request at its bound is ignored so it cannot block the other one
  assign w_eleg_suma  = sol_suma  & ~w_lleno;
  assign w_eleg_resta = sol_resta & ~w_vacio;

  assign w_grant_suma  = w_eleg_suma  & (~w_eleg_resta |  r_prio_suma);
  assign w_grant_resta = w_eleg_resta & (~w_eleg_suma  | ~r_prio_suma);

  // State, priority and registered outputs; reset aborts any grant in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= REPOSO;
      r_prio_suma  <= 1'b1;
      r_actualizar <= 1'b0;
      r_operacion  <= 1'b0;
      r_ack_suma   <= 1'b0;
      r_ack_resta  <= 1'b0;
      r_ocupado    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_prio_suma  <= w_nxt_prio_suma;
      r_actualizar <= w_nxt_actualizar;
      r_operacion  <= w_nxt_operacion;
      r_ack_suma   <= w_nxt_ack_suma;
      r_ack_resta  <= w_nxt_ack_resta;
      r_ocupado    <= w_nxt_ocupado;
    end
  end

  // Next state and next registered outputs; ACTUALIZAR lasts exactly one cycle
  always_comb begin
    w_next_state     = r_state;
    w_nxt_prio_suma  = r_prio_suma;
    w_nxt_actualizar = 1'b0;
    w_nxt_operacion  = r_operacion;
    w_nxt_ack_suma   = 1'b0;
    w_nxt_ack_resta  = 1'b0;
    w_nxt_ocupado    = 1'b0;
    case (r_state)
      REPOSO: begin
        if (w_grant_suma) begin
          w_next_state     = ACTUALIZAR;
          w_nxt_actualizar = 1'b1;
          w_nxt_operacion  = 1'b1;
          w_nxt_ack_suma   = 1'b1;
          w_nxt_ocupado    = 1'b1;
          w_nxt_prio_suma  = 1'b0;
        end else if (w_grant_resta) begin
          w_next_state     = ACTUALIZAR;
          w_nxt_actualizar = 1'b1;
          w_nxt_operacion  = 1'b0;
          w_nxt_ack_resta  = 1'b1;
          w_nxt_ocupado    = 1'b1;
          w_nxt_prio_suma  = 1'b1;
        end
      end
      ACTUALIZAR: w_next_state = REPOSO;
      default:    w_next_state = REPOSO;
    endcase
  end

  assign actualizar = r_actualizar;
  assign operacion  = r_operacion;
  assign ack_suma   = r_ack_suma;
  assign ack_resta  = r_ack_resta;
  assign ocupado    = r_ocupado;
  assign lleno      = w_lleno;
  assign vacio      = w_vacio;

endmodule

// File: tb/tb_arbitro_sumador_restador.sv
// Bench for arbitro_sumador_restador: a behavioural counter is driven by the
// DUT, a reference model predicts every grant into a queue and a monitor
// pops and compares whenever the DUT acknowledges.
module tb_arbitro_sumador_restador;
  localparam int BW   = 4;
  localparam int VMAX = 15;
  localparam int VMIN = 0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sol_suma = 1'b0;
  logic sol_resta = 1'b0;
  logic [BW-1:0] valor_actual;
  logic actualizar, operacion, ack_suma, ack_resta, lleno, vacio, ocupado;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  arbitro_sumador_restador #(.BITS_VALOR(BW), .VALOR_MAX(VMAX), .VALOR_MIN(VMIN)) dut (
    .clk(clk), .reset(reset), .sol_suma(sol_suma), .sol_resta(sol_resta),
    .valor_actual(valor_actual), .actualizar(actualizar), .operacion(operacion),
    .ack_suma(ack_suma), .ack_resta(ack_resta), .lleno(lleno), .vacio(vacio),
    .ocupado(ocupado)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // External up/down counter steered by the DUT; loadable only from the bench
  logic ld = 1'b0;
  int   ld_val = 0;
  int   cnt = 0;
  always @(posedge clk) begin
    if (ld) cnt <= ld_val;
    else if (actualizar) cnt <= operacion ? cnt + 1 : cnt - 1;
  end
  assign valor_actual = cnt[BW-1:0];

  // Reference model: a grant takes one evaluation, the counter moves on the
  // following edge, and conflicts alternate starting with suma.
  typedef struct {
    bit suma;
    int edge_n;
    int val;
  } exp_t;
  exp_t q[$];

  int cyc = 0;
  int m_val = 0;
  bit m_busy = 1'b0;
  bit m_prio_suma = 1'b1;
  bit m_op = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy      <= 1'b0;
      m_prio_suma <= 1'b1;
      if (ld) m_val <= ld_val;
    end else begin
      bit es, er, g;
      cyc <= cyc + 1;
      if (m_busy) begin
        m_val  <= m_op ? m_val + 1 : m_val - 1;
        m_busy <= 1'b0;
      end else begin
        es = sol_suma  && (m_val < VMAX);
        er = sol_resta && (m_val > VMIN);
        if (es || er) begin
          g = es && (!er || m_prio_suma);
          q.push_back('{suma: g, edge_n: cyc + 1, val: m_val});
          m_op        <= g;
          m_busy      <= 1'b1;
          m_prio_suma <= !g;
        end
      end
    end
  end

  // Monitor: pops an expectation for each ack, checks idle cycles otherwise
  bit last_op = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      last_op <= 1'b0;
    end else begin
      chk("lleno", int'(lleno), int'(cnt >= VMAX));
      chk("vacio", int'(vacio), int'(cnt <= VMIN));
      if (ack_suma || ack_resta) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ack_suma", int'(ack_suma), int'(e.suma));
          chk("ack_resta", int'(ack_resta), int'(!e.suma));
          chk("actualizar_on_grant", int'(actualizar), 1);
          chk("ocupado_on_grant", int'(ocupado), 1);
          chk("operacion", int'(operacion), int'(e.suma));
          chk("grant_edge", cyc, e.edge_n);
          chk("value_at_grant", cnt, e.val);
          last_op <= e.suma;
        end
      end else begin
        chk("missing_ack", q.size(), 0);
        chk("actualizar_idle", int'(actualizar), 0);
        chk("ocupado_idle", int'(ocupado), 0);
        chk("operacion_hold", int'(operacion), int'(last_op));
      end
    end
  end

  task automatic chk_outs_zero(input string nm);
    chk({nm, "_actualizar"}, int'(actualizar), 0);
    chk({nm, "_operacion"}, int'(operacion), 0);
    chk({nm, "_ack_suma"}, int'(ack_suma), 0);
    chk({nm, "_ack_resta"}, int'(ack_resta), 0);
    chk({nm, "_ocupado"}, int'(ocupado), 0);
  endtask

  // Assert reset, load the counter, and leave reset just after a falling edge
  task automatic do_reset(input int val, input bit s, input bit r);
    @(negedge clk);
    #1;
    reset = 1'b0;
    sol_suma = 1'b0;
    sol_resta = 1'b0;
    #1;
    chk_outs_zero("reset");
    @(negedge clk);
    ld_val = val;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    sol_suma = s;
    sol_resta = r;
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_ack(input bit s, input int bound, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      #1;
      if (s ? ack_suma : ack_resta) seen = 1'b1;
    end
    chk({nm, "_ack_seen"}, int'(seen), 1);
  endtask

  task automatic run_random(input int n, input int p_raise, input int p_drop);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (sol_suma) begin
        if (ack_suma && ($urandom % 100) < p_drop) sol_suma = 1'b0;
      end else if (($urandom % 100) < p_raise) sol_suma = 1'b1;
      if (sol_resta) begin
        if (ack_resta && ($urandom % 100) < p_drop) sol_resta = 1'b0;
      end else if (($urandom % 100) < p_raise) sol_resta = 1'b1;
    end
  endtask

  initial begin
    int n_act;

    // Single increment from 3
    do_reset(3, 1'b1, 1'b0);
    wait_ack(1'b1, 6, "inc");
    sol_suma = 1'b0;
    repeat (4) @(negedge clk);
    chk("inc_value", cnt, 4);

    // Conflict from 5, both held from reset: suma, resta, suma, resta
    do_reset(5, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    chk("oscillate_value", cnt, 5);
    sol_suma = 1'b0;
    sol_resta = 1'b0;
    repeat (3) @(negedge clk);

    // Upper bound: suma stalls at 15, resta still gets through
    do_reset(15, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    chk("full_lleno", int'(lleno), 1);
    chk("full_no_update", cnt, 15);
    sol_resta = 1'b1;
    wait_ack(1'b0, 4, "full_resta");
    sol_resta = 1'b0;
    wait_ack(1'b1, 6, "full_suma");
    sol_suma = 1'b0;
    repeat (3) @(negedge clk);
    chk("full_back", cnt, 15);

    // Lower bound: resta stalls at 0 for 10 cycles, suma is not blocked
    do_reset(0, 1'b0, 1'b1);
    n_act = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (actualizar) n_act++;
    end
    chk("empty_no_update", n_act, 0);
    chk("empty_vacio", int'(vacio), 1);
    sol_suma = 1'b1;
    wait_ack(1'b1, 4, "empty_suma");
    sol_suma = 1'b0;
    repeat (4) @(negedge clk);
    sol_resta = 1'b0;
    repeat (2) @(negedge clk);
    chk("empty_final", cnt, 0);

    // Reset during ACTUALIZAR aborts the update
    do_reset(7, 1'b1, 1'b0);
    wait_ack(1'b1, 6, "abort");
    #2;
    reset = 1'b0;
    #1;
    chk_outs_zero("abort");
    sol_suma = 1'b0;
    sol_resta = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("abort_value", cnt, 7);
    reset = 1'b1;
    #1;
    chk("abort_no_early_ack", int'(ack_resta), 0);
    wait_ack(1'b0, 4, "abort_resta");
    sol_resta = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_final", cnt, 6);

    // Randomised traffic from random starting values, bounds included
    for (int k = 0; k < 6; k++) begin
      do_reset((k == 0) ? 0 : (k == 1) ? 15 : int'($urandom_range(0, 15)), 1'b0, 1'b0);
      run_random(250, 40, 60);
      sol_suma = 1'b0;
      sol_resta = 1'b0;
      repeat (3) @(negedge clk);
      chk("random_model_value", cnt, m_val);
    end

    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
